// File: rtl/io_led_switch_port_if.sv
// CPU-side MMIO bus bundle for the LED/switch port.
// The CPU bridge is the master and the peripheral is the slave.
interface io_led_switch_port_if;
   logic        iLedCtrl;
   logic        iSwitchCtrl;
   logic [31:0] iAddress;
   logic [31:0] iWriteData;
   logic [15:0] oReadData;

   modport master (
      output iLedCtrl,
      output iSwitchCtrl,
      output iAddress,
      output iWriteData,
      input  oReadData
   );

   modport slave (
      input  iLedCtrl,
      input  iSwitchCtrl,
      input  iAddress,
      input  iWriteData,
      output oReadData
   );
endinterface

// File: rtl/io_led_switch_port.sv
// LED/switch MMIO responder: registered LED outputs and
// synchronised, bank-wide debounced switch read-back.
module io_led_switch_port #(
   parameter int          DEBOUNCE_CYCLES = 100000,
   parameter logic [31:0] LED_BASE        = 32'hFFFFFC60,
   parameter logic [31:0] SW_BASE         = 32'hFFFFFC70
) (
   input  logic                iClock,
   input  logic                iReset,
   io_led_switch_port_if.slave bus,
   input  logic [23:0]         iSwitchPins,
   output logic [23:0]         oLedPins,
   output logic                oSwitchEvent
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [23:0]   r_led;
   logic [23:0]   r_sync1;
   logic [23:0]   r_sync2;
   logic [23:0]   r_stable;
   logic [CW-1:0] r_cnt;
   logic          r_event;

   logic          w_led_lo;
   logic          w_led_hi;
   logic          w_sw_lo;
   logic          w_sw_hi;
   logic [15:0]   w_rd;
   logic          w_unused_wd;

   assign w_led_lo = bus.iLedCtrl && (bus.iAddress == LED_BASE);
   assign w_led_hi = bus.iLedCtrl && (bus.iAddress == LED_BASE + 32'd2);
   assign w_sw_lo  = bus.iSwitchCtrl && (bus.iAddress == SW_BASE);
   assign w_sw_hi  = bus.iSwitchCtrl && (bus.iAddress == SW_BASE + 32'd2);

   assign w_unused_wd = ^bus.iWriteData[31:16];

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         r_led <= '0;
      end else begin
         if (w_led_lo) r_led[15:0]  <= bus.iWriteData[15:0];
         if (w_led_hi) r_led[23:16] <= bus.iWriteData[7:0];
      end
   end

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= iSwitchPins;
         r_sync2 <= r_sync1;
      end
   end

   // One counter for the whole bank: it only clears once every bit agrees again
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         r_stable <= '0;
         r_cnt    <= '0;
         r_event  <= 1'b0;
      end else begin
         r_event <= 1'b0;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CMAX) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
            r_event  <= 1'b1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_rd = 16'h0000;
      unique case (1'b1)
         w_sw_lo: w_rd = r_stable[15:0];
         w_sw_hi: w_rd = {8'h00, r_stable[23:16]};
         default: w_rd = 16'h0000;
      endcase
   end

   assign bus.oReadData = w_rd;
   assign oLedPins      = r_led;
   assign oSwitchEvent  = r_event;

endmodule

// File: tb/tb_io_led_switch_port.sv
// Randomised and directed bench for io_led_switch_port,
// checked every cycle against a window-based debounce model.
module tb_io_led_switch_port;

   localparam int          D        = 4;
   localparam logic [31:0] LED_BASE = 32'hFFFFFC60;
   localparam logic [31:0] SW_BASE  = 32'hFFFFFC70;

   logic        clk  = 1'b0;
   logic        rst  = 1'b1;
   logic [23:0] pins = '0;
   logic [23:0] led;
   logic        ev;

   io_led_switch_port_if bus ();

   io_led_switch_port #(
      .DEBOUNCE_CYCLES (D),
      .LED_BASE        (LED_BASE),
      .SW_BASE         (SW_BASE)
   ) dut (
      .iClock       (clk),
      .iReset       (rst),
      .bus          (bus),
      .iSwitchPins  (pins),
      .oLedPins     (led),
      .oSwitchEvent (ev)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Behavioural model: pins reach the debouncer two samples late; a
   // new value is accepted once the last D samples since the previous
   // acceptance all disagree with the accepted value.
   logic [23:0] m_s1 = '0;
   logic [23:0] m_s2 = '0;
   logic [23:0] m_st = '0;
   logic [23:0] m_led = '0;
   logic        m_ev = 1'b0;
   logic [23:0] win[$];

   function automatic logic [15:0] rd_model(input logic cs,
                                            input logic [31:0] a,
                                            input logic [23:0] st);
      if (cs && a == SW_BASE)        return st[15:0];
      if (cs && a == SW_BASE + 32'd2) return {8'h00, st[23:16]};
      return 16'h0000;
   endfunction

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_s1 = '0; m_s2 = '0; m_st = '0;
            m_led = '0; m_ev = 1'b0;
            win.delete();
         end else begin
            bit all_diff;
            win.push_back(m_s2);
            if (win.size() > D) void'(win.pop_front());
            all_diff = (win.size() == D);
            foreach (win[i]) if (win[i] == m_st) all_diff = 1'b0;
            m_ev = all_diff;
            if (all_diff) begin
               m_st = m_s2;
               win.delete();
            end
            m_s2 = m_s1;
            m_s1 = pins;
            if (bus.iLedCtrl && bus.iAddress == LED_BASE)
               m_led[15:0] = bus.iWriteData[15:0];
            if (bus.iLedCtrl && bus.iAddress == LED_BASE + 32'd2)
               m_led[23:16] = bus.iWriteData[7:0];
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            check("model_led", {8'h0, led}, {8'h0, m_led});
            check("model_event", {31'h0, ev}, {31'h0, m_ev});
            check("model_rdata", {16'h0, bus.oReadData},
                  {16'h0, rd_model(bus.iSwitchCtrl, bus.iAddress, m_st)});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_bus();
      bus.iLedCtrl    = 1'b0;
      bus.iSwitchCtrl = 1'b0;
      bus.iAddress    = '0;
      bus.iWriteData  = '0;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      pins = '0;
      idle_bus();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic led_wr(input logic [31:0] a, input logic [31:0] d);
      bus.iLedCtrl   = 1'b1;
      bus.iAddress   = a;
      bus.iWriteData = d;
      tick();
      bus.iLedCtrl   = 1'b0;
   endtask

   task automatic sw_rd(input logic [31:0] a, input logic [15:0] exp,
                        input string name);
      bus.iSwitchCtrl = 1'b1;
      bus.iAddress    = a;
      #1;
      check(name, {16'h0, bus.oReadData}, {16'h0, exp});
   endtask

   initial begin
      idle_bus();
      do_reset();
      cmp_en = 1'b1;

      // LED writes to both halves; an unmapped offset is ignored
      led_wr(LED_BASE, 32'h0000A5A5);
      led_wr(LED_BASE + 32'd2, 32'h0000003C);
      check("led_write", {8'h0, led}, 32'h003CA5A5);
      led_wr(LED_BASE + 32'd4, 32'h0000FFFF);
      check("led_bad_addr", {8'h0, led}, 32'h003CA5A5);

      // Asynchronous reset with a populated switch bank
      pins = 24'hFFFFFF;
      repeat (8) tick();
      sw_rd(SW_BASE, 16'hFFFF, "pre_reset_rd");
      rst = 1'b1;
      #1;
      check("reset_led", {8'h0, led}, 32'h0);
      check("reset_rd", {16'h0, bus.oReadData}, 32'h0);
      check("reset_ev", {31'h0, ev}, 32'h0);
      do_reset();

      // Debounce accept: event exactly six edges after the pin change
      pins = 24'h00F00F;
      for (int k = 1; k <= 6; k++) begin
         tick();
         check($sformatf("accept_ev_%0d", k), {31'h0, ev},
               (k == 6) ? 32'h1 : 32'h0);
      end
      sw_rd(SW_BASE, 16'hF00F, "accept_rd_lo");
      sw_rd(SW_BASE + 32'd2, 16'h0000, "accept_rd_hi");
      tick();
      check("accept_ev_once", {31'h0, ev}, 32'h0);
      idle_bus();

      // Bounce shorter than the debounce window is rejected
      do_reset();
      begin
         int evs = 0;
         pins = 24'h000001;
         repeat (3) tick();
         pins = 24'h000000;
         for (int k = 0; k < 10; k++) begin
            tick();
            evs += int'(ev);
         end
         check("bounce_events", evs, 0);
         sw_rd(SW_BASE, 16'h0000, "bounce_rd");
         idle_bus();
      end

      // Concurrent chip selects are served independently
      do_reset();
      pins = 24'hAB0000;
      repeat (8) tick();
      bus.iLedCtrl    = 1'b1;
      bus.iSwitchCtrl = 1'b1;
      bus.iAddress    = SW_BASE + 32'd2;
      bus.iWriteData  = 32'h00001234;
      #1;
      check("conc_rd_same_cycle", {16'h0, bus.oReadData}, 32'h00AB);
      tick();
      check("conc_led_unmapped", {8'h0, led}, 32'h0);
      bus.iAddress   = LED_BASE;
      bus.iWriteData = 32'h00005A5A;
      #1;
      check("conc_rd_led_addr", {16'h0, bus.oReadData}, 32'h0);
      check("conc_led_before_edge", {8'h0, led}, 32'h0);
      tick();
      check("conc_led_landed", {8'h0, led}, 32'h005A5A);
      idle_bus();

      // Reset mid-count restarts the full latency
      do_reset();
      pins = 24'h000001;
      repeat (4) tick();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         check($sformatf("restart_ev_%0d", k), {31'h0, ev},
               (k == 6) ? 32'h1 : 32'h0);
      end

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         int sel;
         if ($urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 1) == 0) pins = 24'($urandom);
            else pins = pins ^ (24'h1 << $urandom_range(0, 23));
         end
         sel = $urandom_range(0, 5);
         unique case (sel)
            0: bus.iAddress = LED_BASE;
            1: bus.iAddress = LED_BASE + 32'd2;
            2: bus.iAddress = SW_BASE;
            3: bus.iAddress = SW_BASE + 32'd2;
            4: bus.iAddress = LED_BASE + 32'd4;
            default: bus.iAddress = $urandom;
         endcase
         bus.iLedCtrl    = 1'($urandom_range(0, 1));
         bus.iSwitchCtrl = 1'($urandom_range(0, 1));
         bus.iWriteData  = $urandom;
         rst = ($urandom_range(0, 399) == 0);
         tick();
      end
      rst = 1'b0;
      idle_bus();
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
